// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard, optional
// write-to-read bypass and a sequenced clear engine that zeroes the storage
// array one entry per clock after reset or on clear_req.
//
// Handshake: ready is a registered level. While ready is 0 the file is being
// swept: write-back and issue strobes are dropped and every read port returns
// data 0 / busy 0. When ready is 1, wr_en and issue_en act on the rising edge
// they are sampled on, and reads are purely combinational.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     clear_req,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DEPTH-1:0]    busy;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic wr_fire;
  logic iss_fire;

  // Register 0 is never written and never marked busy when hardwired to zero.
  assign wr_fire  = ready && wr_en &&
                    !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_fire = ready && issue_en &&
                    !((ZERO_REG != 0) && (issue_addr == '0));

  // Clear-engine FSM: sweep pointer through every entry, then sit in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Busy scoreboard: completion clears, new issue sets; set is applied last so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if ((state == IDLE) && clear_req) begin
      busy <= '0;
    end else begin
      if (wr_fire) busy[wr_addr] <= 1'b0;
      if (iss_fire) busy[issue_addr] <= 1'b1;
    end
  end

  // Storage array has no reset; the sweep zeroes it, otherwise write-back updates it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    // Read port select: blanked while sweeping, zero register, bypass, then array.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (!ready) begin
        data = '0;
        bsy  = 1'b0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
        data = wr_data;
        bsy  = 1'b0;
      end else begin
        data = mem[addr];
        bsy  = busy[addr];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances share all inputs, one with
// bypass and one without. A driver issues one stimulus cycle at a time and
// pushes the reference model's expected read results; a monitor pops and
// compares shortly after each falling edge.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_n = 1'b0;
  logic                     rst_drive = 1'b0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD*DATA_W-1:0] rd_data_nb;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD-1:0]        rd_busy_nb;
  logic                     wr_en = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     issue_en = 1'b0;
  logic [ADDR_W-1:0]        issue_addr = '0;
  logic                     clear_req = 1'b0;
  logic                     ready;
  logic                     ready_nb;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(1), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .clear_req(clear_req),
    .ready(ready)
  );

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(0), .ZERO_REG(1)
  ) u_nb (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .clear_req(clear_req),
    .ready(ready_nb)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_busy [DEPTH];
  int                m_clear_left = DEPTH;

  typedef struct packed {
    logic                     rdy;
    logic [NUM_RD-1:0]        busy;
    logic [NUM_RD*DATA_W-1:0] data;
    logic [NUM_RD-1:0]        busy_nb;
    logic [NUM_RD*DATA_W-1:0] data_nb;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  function automatic exp_t model_expect();
    exp_t e;
    logic [ADDR_W-1:0] a;
    e = '0;
    e.rdy = (m_clear_left == 0);
    if (e.rdy) begin
      for (int k = 0; k < NUM_RD; k++) begin
        a = rd_addr[k*ADDR_W +: ADDR_W];
        if (a != 0) begin
          e.data_nb[k*DATA_W +: DATA_W] = m_mem[a];
          e.busy_nb[k]                  = m_busy[a];
          if (wr_en && wr_addr == a) begin
            e.data[k*DATA_W +: DATA_W] = wr_data;
            e.busy[k]                  = 1'b0;
          end else begin
            e.data[k*DATA_W +: DATA_W] = m_mem[a];
            e.busy[k]                  = m_busy[a];
          end
        end
      end
    end
    return e;
  endfunction

  task automatic model_zero_all();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Effect of one rising edge, using the inputs held during that cycle.
  task automatic model_edge();
    if (!reset_n) begin
      m_clear_left = DEPTH;
      model_zero_all();
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (clear_req) begin
      m_clear_left = DEPTH;
      model_zero_all();
    end else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready",      64'(ready),      64'(e.rdy));
        check("ready_nb",   64'(ready_nb),   64'(e.rdy));
        check("rd_busy",    64'(rd_busy),    64'(e.busy));
        check("rd_busy_nb", 64'(rd_busy_nb), 64'(e.busy_nb));
        check("rd_data",    rd_data,         e.data);
        check("rd_data_nb", rd_data_nb,      e.data_nb);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic cr);
    @(negedge clk);
    reset_n    = rst_drive;
    rd_addr    = {a1, a0};
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    clear_req  = cr;
    exp_q.push_back(model_expect());
    @(posedge clk);
    model_edge();
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    cycle(a0, a1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH / 2; i++) rd(5'(2 * i), 5'(2 * i + 1));
  endtask

  // Drop reset_n between edges and check outputs collapse without a clock.
  task automatic async_reset(input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    reset_n   = rst_drive;
    rd_addr   = {a1, a0};
    wr_en     = 1'b0;
    issue_en  = 1'b0;
    clear_req = 1'b0;
    exp_q.push_back(model_expect());
    #3;
    reset_n = 1'b0;
    #1;
    check("async_ready",    64'(ready),    64'd0);
    check("async_ready_nb", 64'(ready_nb), 64'd0);
    check("async_rd_busy",  64'(rd_busy),  64'd0);
    check("async_rd_data",  rd_data,       64'd0);
    @(posedge clk);
    model_edge();
    rst_drive = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    model_zero_all();

    // Reset held, then sweep with a write to reg 3 that must be dropped.
    repeat (3) rd(5'd1, 5'd3);
    rst_drive = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      cycle(5'd3, rnd_addr(), 1'b1, 5'd3, $urandom, 1'b0, 5'd0, 1'b0);
    read_all();

    // Write / bypass on reg 7.
    cycle(5'd7, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    rd(5'd7, 5'd7);

    // Register 0 ignores writes and issue.
    cycle(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0);
    rd(5'd0, 5'd0);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
    rd(5'd0, 5'd7);

    // Scoreboard on reg 9.
    cycle(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
    rd(5'd9, 5'd9);
    cycle(5'd9, 5'd9, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
    rd(5'd9, 5'd9);
    cycle(5'd9, 5'd9, 1'b1, 5'd9, 32'h5A5A5A5A, 1'b1, 5'd9, 1'b0);
    rd(5'd9, 5'd9);

    // Fill 1..31, mark a few busy, clear, re-request mid-sweep.
    for (int i = 1; i < DEPTH; i++)
      cycle(5'(i), 5'(i), 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0);
    cycle(5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0);
    cycle(5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0);
    read_all();
    cycle(5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(5'd5, 5'd6, 1'b1, 5'd4, 32'hFFFF, 1'b1, 5'd5, (i == 10) ? 1'b1 : 1'b0);
    read_all();

    // Async reset in IDLE with busy bits set.
    cycle(5'd12, 5'd13, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0);
    cycle(5'd12, 5'd13, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0);
    rd(5'd12, 5'd13);
    async_reset(5'd12, 5'd13);
    rd(5'd12, 5'd13);
    rst_drive = 1'b1;
    for (int i = 0; i < 10; i++) rd(rnd_addr(), rnd_addr());

    // Async reset mid-sweep: the sweep restarts from index 0.
    rst_drive = 1'b1;
    async_reset(5'd1, 5'd2);
    rd(5'd1, 5'd2);
    rst_drive = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) rd(rnd_addr(), rnd_addr());
    read_all();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(rnd_addr(), rnd_addr(),
            1'($urandom_range(0, 1)), rnd_addr(), $urandom,
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, rnd_addr(),
            ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #3;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
